// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed
// 7-segment driver. Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic seg_t hex2seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h18;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      4'hF: hex2seg = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot prescaler and digit index for the display scan. tick marks the last
// cycle of a slot, wrap marks the last cycle of a whole frame.
module scan_timer #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000,
  localparam int IW      = $clog2(NDIG),
  localparam int CW      = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          tick,
  output logic          wrap
);

  assign tick = (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/deco7seg_scan.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned value
// updates, leading-zero suppression and anode dead time at slot start.
module deco7seg_scan
  import seg7_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   blank,
  input  logic              lz_en,
  input  logic              load,
  output logic [6:0]        SEG,
  output logic              DP,
  output logic [NDIG-1:0]   AN,
  output logic              frame_done
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              wrap;
  logic              boundary;

  logic [4*NDIG-1:0] stg_value;
  logic [NDIG-1:0]   stg_dp;
  logic [NDIG-1:0]   stg_blank;
  logic [4*NDIG-1:0] shd_value;
  logic [NDIG-1:0]   shd_dp;
  logic [NDIG-1:0]   shd_blank;
  logic              pending;

  logic [NDIG-1:0]   suppress;
  logic [3:0]        cur_nib;
  seg_t              seg_next;
  logic              dp_next;
  logic [NDIG-1:0]   an_next;

  scan_timer #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .idx   (idx),
    .tick  (tick),
    .wrap  (wrap)
  );

  assign boundary = tick && (idx == IW'(NDIG - 1));

  // Loads go to staging and are promoted only at a frame boundary, so a
  // frame never mixes digits of two values; a load on the boundary skips staging.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_value <= '0;
      stg_dp    <= '0;
      stg_blank <= '0;
      shd_value <= '0;
      shd_dp    <= '0;
      shd_blank <= '0;
      pending   <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        shd_value <= value;
        shd_dp    <= dp;
        shd_blank <= blank;
      end else if (pending) begin
        shd_value <= stg_value;
        shd_dp    <= stg_dp;
        shd_blank <= stg_blank;
      end
      pending <= 1'b0;
    end else if (load) begin
      stg_value <= value;
      stg_dp    <= dp;
      stg_blank <= blank;
      pending   <= 1'b1;
    end
  end

  // Scan from the top digit down; blanked digits are transparent, so the
  // next higher visible digit decides whether a zero counts as leading.
  always_comb begin
    logic lead;
    suppress = '0;
    lead     = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      lead        = lead & ((shd_value[4*k +: 4] == 4'h0) | shd_blank[k]);
      suppress[k] = lz_en & lead & (k != 0);
    end
  end

  always_comb begin
    cur_nib  = shd_value[4*idx +: 4];
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    an_next  = '1;
    if (!shd_blank[idx]) begin
      dp_next = ~shd_dp[idx];
      if (!suppress[idx]) begin
        seg_next = hex2seg(cur_nib);
      end
    end
    if (int'(cnt) >= BLANK_CYC) begin
      an_next[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      SEG        <= SEG_OFF;
      DP         <= 1'b1;
      AN         <= '1;
      frame_done <= 1'b0;
    end else begin
      SEG        <= seg_next;
      DP         <= dp_next;
      AN         <= an_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_deco7seg_scan.sv
// Directed bench for deco7seg_scan with NDIG=4, SCAN_DIV=4, BLANK_CYC=1;
// expected segment codes are written out by hand per frame.
module tb_deco7seg_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lzEn;
  logic        load;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;
  logic        frameDone;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  deco7seg_scan #(
    .NDIG      (4),
    .SCAN_DIV  (4),
    .BLANK_CYC (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lzEn),
    .load       (load),
    .SEG        (SEG),
    .DP         (DP),
    .AN         (AN),
    .frame_done (frameDone)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; holds load for exactly one rising edge.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] b, input logic l);
    value = v;
    dp    = d;
    blank = b;
    lzEn  = l;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic waitFrame(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frameDone !== 1'b1 && cycles < 40);
    if (frameDone !== 1'b1) checkOutput("frame_timeout", {31'd0, frameDone}, 32'd1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_seg"}, {25'd0, SEG}, 32'h7F);
    checkOutput({tag, "_an"}, {28'd0, AN}, 32'hF);
    checkOutput({tag, "_dp"}, {31'd0, DP}, 32'd1);
    checkOutput({tag, "_fd"}, {31'd0, frameDone}, 32'd0);
  endtask

  // Starts right after a frame_done sample; segs = {d3,d2,d1,d0}, dpOut is DP pin per digit.
  task automatic checkFrame(input string tag, input logic [27:0] segs,
                            input logic [3:0] dpOut);
    logic [3:0] expAn;
    for (int s = 0; s < 16; s++) begin
      int d = s / 4;
      int c = s % 4;
      @(negedge clk);
      expAn = (c >= 1) ? ~(4'b0001 << d) : 4'hF;
      checkOutput($sformatf("%s_an%0d", tag, s), {28'd0, AN}, {28'd0, expAn});
      checkOutput($sformatf("%s_seg%0d", tag, s), {25'd0, SEG}, {25'd0, segs[7*d +: 7]});
      checkOutput($sformatf("%s_dp%0d", tag, s), {31'd0, DP}, {31'd0, dpOut[d]});
      checkOutput($sformatf("%s_fd%0d", tag, s), {31'd0, frameDone}, {31'd0, (s == 15)});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    value = '0;
    dp    = '0;
    blank = '0;
    lzEn  = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("rst");

    reset = 1'b0;
    @(negedge clk);
    checkOutput("start_an_c0", {28'd0, AN}, 32'hF);
    checkOutput("start_seg_c0", {25'd0, SEG}, 32'h40);
    @(negedge clk);
    checkOutput("start_an_c1", {28'd0, AN}, 32'hE);
    waitFrame(n);
    checkOutput("first_fd_cycle", n + 2, 32'd16);

    applyStimulus(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    waitFrame(n);
    checkOutput("load_fd_gap", n, 32'd15);
    checkFrame("hex12af", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);

    applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
    waitFrame(n);
    checkOutput("pre_switch_seg", {25'd0, SEG}, 32'h79);
    checkOutput("pre_switch_an", {28'd0, AN}, 32'h7);
    checkFrame("last_load", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);

    applyStimulus(16'h0040, 4'b1000, 4'b0000, 1'b1);
    waitFrame(n);
    checkFrame("lz_0040", {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b0111);

    applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
    waitFrame(n);
    checkFrame("lz_zero", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

    applyStimulus(16'h0000, 4'b0000, 4'b0001, 1'b1);
    waitFrame(n);
    checkFrame("blank_d0", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF);

    applyStimulus(16'h8888, 4'b0000, 4'b0000, 1'b0);
    repeat (9) @(negedge clk);
    checkOutput("pre_rst_an", {28'd0, AN}, 32'hB);
    checkOutput("pre_rst_seg", {25'd0, SEG}, 32'h40);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkReset("midrst");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("restart_an_c0", {28'd0, AN}, 32'hF);
    checkOutput("restart_seg_c0", {25'd0, SEG}, 32'h40);
    @(negedge clk);
    checkOutput("restart_an_c1", {28'd0, AN}, 32'hE);
    waitFrame(n);
    checkOutput("restart_fd_cycle", n + 2, 32'd16);
    checkFrame("after_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
